viterbi_acs_array: RTL

Parametrised add-compare-select array for the convolutional (Viterbi) decoder: computes all 2^(K-1) trellis states in parallel, one trellis step per accepted symbol. It holds the path metrics in registers, normalises and saturates them, and emits one decision bit per state. The block sits between the branch-metric unit (upstream) and the traceback/survivor memory (downstream). It also reports the best state and metric each step so traceback can start from the best state.

---
 rtl/viterbi_acs_array.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/viterbi_acs_array.sv
// viterbi_acs_array: add-compare-select over all 2^(K-1) trellis states in parallel.
// Holds path metrics, renormalises them, saturates sums and reports per-state
// decisions plus the best (minimum-metric) state for traceback.
module viterbi_acs_array #(
  parameter int unsigned  K  = 7,
  parameter logic [K-1:0] G0 = 7'o133,
  parameter logic [K-1:0] G1 = 7'o171,
  parameter int unsigned  MW = 7,
  parameter int unsigned  BW = 2,
  localparam int unsigned NS = 2 ** (K - 1),
  localparam int unsigned SW = K - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          start,
  input  logic [BW-1:0] bm00,
  input  logic [BW-1:0] bm01,
  input  logic [BW-1:0] bm10,
  input  logic [BW-1:0] bm11,
  output logic          out_valid,
  output logic [NS-1:0] decisions,
  output logic [SW-1:0] best_state,
  output logic [MW-1:0] best_metric,
  output logic          norm_event
);

  localparam int unsigned   SUMW = MW + 1;
  localparam logic [MW-1:0] HALF = {1'b1, {(MW - 1){1'b0}}};
  localparam logic [MW-1:0] SAT  = {MW{1'b1}};

  logic [MW-1:0] metric_q [NS];
  logic [MW-1:0] addend   [NS];
  logic [MW-1:0] metric_d [NS];
  logic [NS-1:0] dec_d;
  logic [BW-1:0] bm_tab   [4];
  logic          all_msb;
  logic          do_norm;
  logic [SW-1:0] best_state_d;
  logic [MW-1:0] best_metric_d;

  // Branch metrics indexed by hypothesised codeword {a, b}.
  assign bm_tab[0] = bm00;
  assign bm_tab[1] = bm01;
  assign bm_tab[2] = bm10;
  assign bm_tab[3] = bm11;

  // Every stored metric is in the upper half: safe to subtract HALF from all.
  always_comb begin
    all_msb = 1'b1;
    for (int i = 0; i < NS; i++) begin
      all_msb = all_msb & metric_q[i][MW-1];
    end
  end

  // A frame start overrides normalisation.
  assign do_norm = ~start & all_msb;

  // Addend per state: frame restart pattern, normalised metric, or stored metric.
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      if (start) begin
        addend[i] = (i == 0) ? '0 : HALF;
      end else if (all_msb) begin
        addend[i] = metric_q[i] - HALF;
      end else begin
        addend[i] = metric_q[i];
      end
    end
  end

  // One butterfly half per next state n; predecessor wiring and codewords are
  // fixed at elaboration time from the generator polynomials.
  for (genvar n = 0; n < NS; n++) begin : g_acs
    localparam logic [SW-1:0] NV = SW'(n);
    localparam logic [SW-1:0] P0 = {NV[SW-2:0], 1'b0};
    localparam logic [SW-1:0] P1 = {NV[SW-2:0], 1'b1};
    localparam logic [K-1:0]  R0 = {NV[SW-1], P0};
    localparam logic [K-1:0]  R1 = {NV[SW-1], P1};
    localparam logic [1:0]    C0 = {^(R0 & G0), ^(R0 & G1)};
    localparam logic [1:0]    C1 = {^(R1 & G0), ^(R1 & G1)};

    logic [SUMW-1:0] sum0;
    logic [SUMW-1:0] sum1;
    logic [MW-1:0]   sat0;
    logic [MW-1:0]   sat1;
    logic            pick1;

    assign sum0 = SUMW'(addend[P0]) + SUMW'(bm_tab[C0]);
    assign sum1 = SUMW'(addend[P1]) + SUMW'(bm_tab[C1]);
    assign sat0 = sum0[MW] ? SAT : sum0[MW-1:0];
    assign sat1 = sum1[MW] ? SAT : sum1[MW-1:0];
    // Lower metric wins; a tie goes to the odd predecessor.
    assign pick1       = (sat0 >= sat1);
    assign dec_d[n]    = pick1;
    assign metric_d[n] = pick1 ? sat1 : sat0;
  end

  // Pairwise minimum tree; the lower-index operand wins ties.
  always_comb begin
    logic [MW-1:0] lvl_m [NS];
    logic [SW-1:0] lvl_s [NS];
    for (int i = 0; i < NS; i++) begin
      lvl_m[i] = metric_d[i];
      lvl_s[i] = SW'(i);
    end
    for (int lv = 1; lv <= int'(SW); lv++) begin
      for (int i = 0; i < int'(NS >> lv); i++) begin
        if (lvl_m[2*i+1] < lvl_m[2*i]) begin
          lvl_m[i] = lvl_m[2*i+1];
          lvl_s[i] = lvl_s[2*i+1];
        end else begin
          lvl_m[i] = lvl_m[2*i];
          lvl_s[i] = lvl_s[2*i];
        end
      end
    end
    best_metric_d = lvl_m[0];
    best_state_d  = lvl_s[0];
  end

  // Path-metric store; reset pattern favours state 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) begin
        metric_q[i] <= (i == 0) ? '0 : HALF;
      end
    end else if (in_valid) begin
      for (int i = 0; i < NS; i++) begin
        metric_q[i] <= metric_d[i];
      end
    end
  end

  // Step outputs: valid/norm pulse per step, decisions and best_* hold between steps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      norm_event  <= 1'b0;
      decisions   <= '0;
      best_state  <= '0;
      best_metric <= '0;
    end else begin
      out_valid  <= in_valid;
      norm_event <= in_valid & do_norm;
      if (in_valid) begin
        decisions   <= dec_d;
        best_state  <= best_state_d;
        best_metric <= best_metric_d;
      end
    end
  end

endmodule
